// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles.
// Optional signed-overflow output enabled by SERSUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bf_q, bf_d;
  logic             borrow_q, borrow_d;
`ifdef SERSUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
`endif

  logic           x, y, d, bnext;
  logic [WIDTH:0] sr_cat;

  // One full-subtractor slice per cycle
  assign x      = sa_q[0];
  assign y      = sb_q[0];
  assign d      = x ^ y ^ bf_q;
  assign bnext  = (~x & y) | (~(x ^ y) & bf_q);
  assign sr_cat = {d, sr_q};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bf_d     = bf_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVF_EN
    ovf_d    = ovf_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_SHIFT;
          sa_d    = a;
          sb_d    = b;
          bf_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERSUB_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_cat[WIDTH:1];
        bf_d  = bnext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d  = S_DONE;
          diff_d   = sr_cat[WIDTH:1];
          borrow_d = bnext;
`ifdef SERSUB_OVF_EN
          ovf_d    = (amsb_q ^ bmsb_q) & (amsb_q ^ d);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bf_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf_q    <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bf_q     <= bf_d;
      borrow_q <= borrow_d;
`ifdef SERSUB_OVF_EN
      ovf_q    <= ovf_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
`endif
    end
  end

  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Vector table plus scoreboard queue; hand-written corner sequences.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       busy1, done1, borrow1;
  logic [0:0] diff1;
`ifdef SERSUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
`ifdef SERSUB_OVF_EN
    .ovf(ovf8),
`endif
    .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1),
`ifdef SERSUB_OVF_EN
    .ovf(ovf1),
`endif
    .borrow(borrow1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive a request; returns after the accept edge (+1)
  task automatic accept8(logic [7:0] a, logic [7:0] b, bit push);
    exp_t e;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    if (push) begin
      e.d  = a - b;
      e.bo = (a < b);
      e.ov = (a[7] ^ b[7]) & (a[7] ^ e.d[7]);
      q.push_back(e);
    end
  endtask

  // Waits for done; edges counted from the accept edge
  task automatic wait_done8(output int edges, output int busyc);
    edges = -1;
    busyc = busy8 ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (busy8 && done8) check("busy_and_done", 1, 0);
      if (done8) begin
        edges = i;
        break;
      end
      if (busy8) busyc++;
    end
    if (edges < 0) check("done_timeout", 0, 1);
  endtask

  task automatic score8(string tag);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = q.pop_front();
    check({tag, "_diff"}, diff8, e.d);
    check({tag, "_borrow"}, borrow8, e.bo);
`ifdef SERSUB_OVF_EN
    check({tag, "_ovf"}, ovf8, e.ov);
`endif
  endtask

  vec_t vt[6];
  int   ed, bc;
  logic [1:0] ab;
  logic       sd;

  initial begin
    vt[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vt[3] = '{8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0};
    vt[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[5] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_diff", diff8, 0);
    check("rst_borrow", borrow8, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors
    foreach (vt[i]) begin
      accept8(vt[i].a, vt[i].b, 1'b1);
      check("tab_busy_e0", busy8, 1);
      wait_done8(ed, bc);
      check("tab_latency", ed, 8);
      check("tab_busy_cycles", bc, 8);
      check("tab_diff_const", diff8, {24'b0, vt[i].d});
      check("tab_borrow_const", borrow8, {31'b0, vt[i].bo});
`ifdef SERSUB_OVF_EN
      check("tab_ovf_const", ovf8, {31'b0, vt[i].ov});
`endif
      score8("tab");
      @(posedge clk);
      #1;
      check("tab_done_drop", done8, 0);
      check("tab_hold_diff", diff8, {24'b0, vt[i].d});
    end

    // start during SHIFT is ignored
    accept8(8'h10, 8'h01, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a8 = 8'hFF;
    b8 = 8'h00;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(ed, bc);
    check("ign_latency", ed, 5);
    check("ign_diff_const", diff8, 32'h0F);
    score8("ign");
    @(posedge clk);
    #1;
    check("ign_idle", busy8, 0);

    // Reset in the middle of SHIFT
    accept8(8'h55, 8'h11, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_busy", busy8, 0);
    check("mrst_done", done8, 0);
    check("mrst_diff", diff8, 0);
    check("mrst_borrow", borrow8, 0);
`ifdef SERSUB_OVF_EN
    check("mrst_ovf", ovf8, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    sd = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) sd = 1'b1;
    end
    check("mrst_no_done", sd, 0);
    accept8(8'h20, 8'h21, 1'b1);
    wait_done8(ed, bc);
    check("mrst_latency", ed, 8);
    check("mrst_diff_const", diff8, 32'hFF);
    score8("mrst");

    // Back-to-back: start held in the DONE cycle
    a8 = 8'h03;
    b8 = 8'h05;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check("b2b_busy", busy8, 1);
    check("b2b_done_low", done8, 0);
    begin
      exp_t e;
      e.d = 8'hFE;
      e.bo = 1'b1;
      e.ov = 1'b0;
      q.push_back(e);
    end
    wait_done8(ed, bc);
    check("b2b_gap", ed + 1, 9);
    score8("b2b");
    @(posedge clk);
    #1;

    // WIDTH=1 exhaustive
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      check("w1_busy", busy1, 1);
      @(posedge clk);
      #1;
      check("w1_done", done1, 1);
      check("w1_diff", diff1, {31'b0, ab[1] ^ ab[0]});
      check("w1_borrow", borrow1, {31'b0, ~ab[1] & ab[0]});
`ifdef SERSUB_OVF_EN
      check("w1_ovf", ovf1, {31'b0, ~ab[1] & ab[0]});
`endif
      @(posedge clk);
      #1;
      check("w1_done_drop", done1, 0);
    end

    check("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
